// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the reset sequencer: FSM states, cause bit
// positions and the watchdog width.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    LOCK_WAIT = 2'd0,
    STRETCH   = 2'd1,
    RUN       = 2'd2
  } seq_state_e;

  localparam int CAUSE_LOCK = 0;
  localparam int CAUSE_SW   = 1;
  localparam int CAUSE_WDT  = 2;
  localparam int CAUSE_SRC0 = 3;

  localparam int WDT_BITS = 24;

  // Bits needed to count 0..max_count-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/reset_src_filter.sv
// One reset request source: synchroniser chain, debouncer and edge detector.
// All flops start at the idle level so leaving reset never produces an event.
module reset_src_filter
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter logic        EDGE_FALL       = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic src_i,
  output logic evt_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   deb_q;
  logic                   deb_prev_q;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q     <= {SYNC_STAGES{EDGE_FALL}};
      deb_prev_q <= EDGE_FALL;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], src_i};
      deb_prev_q <= deb_q;
    end
  end

  generate
    if (DEBOUNCE_CYCLES <= 1) begin : g_bypass
      always_ff @(posedge clk_i) begin
        if (rst_i) deb_q <= EDGE_FALL;
        else       deb_q <= synced;
      end
    end else begin : g_debounce
      localparam int unsigned     CNT_W    = cnt_width(DEBOUNCE_CYCLES);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [CNT_W-1:0] cnt_q;

      // Counter stops at CNT_LAST because it clears on the update.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          cnt_q <= '0;
          deb_q <= EDGE_FALL;
        end else if (synced == deb_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
          deb_q <= synced;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign evt_o = (deb_q ^ deb_prev_q) & (deb_q ^ EDGE_FALL);

endmodule

// File: rtl/reset_sequencer.sv
// System reset sequencer: PLL-lock qualification, filtered request sources,
// software request and sticky cause register. Define RESET_SEQUENCER_WATCHDOG_EN
// to build the 24-bit RUN-state watchdog.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned        NUM_SRC         = 2,
  parameter int unsigned        SYNC_STAGES     = 2,
  parameter int unsigned        DEBOUNCE_CYCLES = 1000,
  parameter logic [NUM_SRC-1:0] EDGE_MODE       = {NUM_SRC{1'b1}},
  parameter int unsigned        LOCK_CYCLES     = 255,
  parameter int unsigned        STRETCH_CYCLES  = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pll_locked,
  input  logic [NUM_SRC-1:0] src_in,
  input  logic [NUM_SRC-1:0] src_mask,
  input  logic               sw_reset_req,
  input  logic               cause_clr,
  input  logic               wdt_kick,
  output logic               reset_out,
  output logic               ready,
  output logic [NUM_SRC+2:0] cause
);

  localparam int unsigned CW      = NUM_SRC + 3;
  localparam int unsigned CNT_MAX = (LOCK_CYCLES > STRETCH_CYCLES) ? LOCK_CYCLES : STRETCH_CYCLES;
  localparam int unsigned CNT_W   = cnt_width(CNT_MAX);
  localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0]    CAUSE_POR    = CW'(1) << CAUSE_LOCK;

  seq_state_e             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   reset_out_q;
  logic                   ready_q;
  logic [CW-1:0]          cause_q;
  logic [CW-1:0]          cause_d;
  logic [CW-1:0]          cause_set;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   lock_s;
  logic [NUM_SRC-1:0]     evt;
  logic [NUM_SRC-1:0]     evt_m;
  logic                   wdt_fire;
  logic                   trig;

  always_ff @(posedge clk) begin
    if (reset) lock_sync_q <= '0;
    else       lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
  end
  assign lock_s = lock_sync_q[SYNC_STAGES-1];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    reset_src_filter #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .EDGE_FALL      (EDGE_MODE[i])
    ) u_filter (
      .clk_i(clk),
      .rst_i(reset),
      .src_i(src_in[i]),
      .evt_o(evt[i])
    );
  end

  // Masked events are dropped here, never queued for later.
  assign evt_m = evt & ~src_mask;

`ifdef RESET_SEQUENCER_WATCHDOG_EN
  logic [WDT_BITS-1:0] wdt_q;

  always_ff @(posedge clk) begin
    if (reset || state_q != RUN || wdt_kick) wdt_q <= '0;
    else                                      wdt_q <= wdt_q + WDT_BITS'(1);
  end
  assign wdt_fire = (state_q == RUN) && !wdt_kick && (wdt_q == '1);
`else
  assign wdt_fire = 1'b0 & wdt_kick;
`endif

  assign trig = (|evt_m) | sw_reset_req | wdt_fire;

  always_comb begin
    cause_set = '0;
    if (state_q != LOCK_WAIT) begin
      cause_set[CAUSE_LOCK]             = ~lock_s;
      cause_set[CAUSE_SW]               = sw_reset_req;
      cause_set[CAUSE_WDT]              = wdt_fire;
      cause_set[CW-1:CAUSE_SRC0]        = evt_m;
    end
    // Clear applies first so a same-cycle set survives.
    cause_d = (((state_q == RUN) && cause_clr) ? '0 : cause_q) | cause_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOCK_WAIT;
      cnt_q       <= '0;
      reset_out_q <= 1'b1;
      ready_q     <= 1'b0;
      cause_q     <= CAUSE_POR;
    end else begin
      cause_q <= cause_d;
      unique case (state_q)
        LOCK_WAIT: begin
          if (!lock_s) begin
            cnt_q <= '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_q <= STRETCH;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STRETCH: begin
          if (!lock_s) begin
            state_q <= LOCK_WAIT;
            cnt_q   <= '0;
          end else if (trig) begin
            cnt_q <= '0;
          end else if (cnt_q == STRETCH_LAST) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            reset_out_q <= 1'b0;
            ready_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          cnt_q <= '0;
          if (!lock_s) begin
            state_q     <= LOCK_WAIT;
            reset_out_q <= 1'b1;
            ready_q     <= 1'b0;
          end else if (trig) begin
            state_q     <= STRETCH;
            reset_out_q <= 1'b1;
            ready_q     <= 1'b0;
          end
        end
        default: begin
          state_q     <= LOCK_WAIT;
          cnt_q       <= '0;
          reset_out_q <= 1'b1;
          ready_q     <= 1'b0;
        end
      endcase
    end
  end

  assign reset_out = reset_out_q;
  assign ready     = ready_q;
  assign cause     = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: constant vector table, hand-written corner
// sequences and randomized stimulus against a behavioural model.
module tb_reset_sequencer;

  localparam int NS = 2;
  localparam int SS = 2;
  localparam int DB = 8;
  localparam int LK = 20;
  localparam int ST = 12;
  localparam logic [NS-1:0] EM = 2'b01;
  localparam int CW = NS + 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          pll_locked;
  logic [NS-1:0] src_in;
  logic [NS-1:0] src_mask;
  logic          sw_reset_req;
  logic          cause_clr;
  logic          wdt_kick;
  logic          reset_out;
  logic          ready;
  logic [CW-1:0] cause;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_SRC(NS), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
    .EDGE_MODE(EM), .LOCK_CYCLES(LK), .STRETCH_CYCLES(ST)
  ) dut (
    .clk(clk), .reset(reset), .pll_locked(pll_locked), .src_in(src_in),
    .src_mask(src_mask), .sw_reset_req(sw_reset_req), .cause_clr(cause_clr),
    .wdt_kick(wdt_kick), .reset_out(reset_out), .ready(ready), .cause(cause)
  );

  // ---------------- behavioural model ----------------
  // phase: 0 waiting for lock, 1 stretching, 2 running
  int            m_phase;
  int            m_lockrun;
  int            m_since;
  logic [CW-1:0] m_cause;
  logic [NS-1:0] m_deb;
  logic [NS-1:0] m_evt;
  int            m_run [NS];
  logic          q_lock [$];
  logic [NS-1:0] q_src [$];
  logic          m_rst;
  logic          m_rdy;

  task automatic model_reset();
    m_phase   = 0;
    m_lockrun = 0;
    m_since   = 0;
    m_cause   = CW'(1);
    m_deb     = EM;
    m_evt     = '0;
    for (int i = 0; i < NS; i++) m_run[i] = 0;
    q_lock.delete();
    q_src.delete();
    for (int k = 0; k < SS; k++) begin
      q_lock.push_back(1'b0);
      q_src.push_back(EM);
    end
    m_rst = 1'b1;
    m_rdy = 1'b0;
  endtask

  task automatic model_step();
    logic          syn_l;
    logic [NS-1:0] syn_s;
    logic [NS-1:0] trig_src;
    logic [NS-1:0] new_evt;
    logic          trig;
    logic [CW-1:0] set;
    if (reset) begin
      model_reset();
      return;
    end
    // values visible to the logic are the samples taken SS edges ago
    syn_l = q_lock.pop_front();
    q_lock.push_back(pll_locked);
    syn_s = q_src.pop_front();
    q_src.push_back(src_in);

    trig_src = m_evt & ~src_mask;
    trig     = (trig_src != '0) || sw_reset_req;

    set = '0;
    if (m_phase != 0) set = {trig_src, 1'b0, sw_reset_req, ~syn_l};
    m_cause = (((m_phase == 2) && cause_clr) ? '0 : m_cause) | set;

    case (m_phase)
      0: begin
        if (syn_l) begin
          m_lockrun++;
          if (m_lockrun == LK) begin m_phase = 1; m_since = 0; end
        end else m_lockrun = 0;
      end
      1: begin
        if (!syn_l) begin m_phase = 0; m_lockrun = 0; end
        else if (trig) m_since = 0;
        else begin
          m_since++;
          if (m_since == ST) m_phase = 2;
        end
      end
      default: begin
        if (!syn_l) begin m_phase = 0; m_lockrun = 0; end
        else if (trig) begin m_phase = 1; m_since = 0; end
      end
    endcase

    new_evt = '0;
    for (int i = 0; i < NS; i++) begin
      if (syn_s[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] >= ((DB == 0) ? 1 : DB)) begin
          m_deb[i] = syn_s[i];
          m_run[i] = 0;
          if (m_deb[i] != EM[i]) new_evt[i] = 1'b1;
        end
      end else m_run[i] = 0;
    end
    m_evt = new_evt;

    m_rst = (m_phase != 2);
    m_rdy = (m_phase == 2);
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 20)
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("model_reset_out", 32'(reset_out), 32'(m_rst));
    check("model_ready", 32'(ready), 32'(m_rdy));
    check("model_cause", 32'(cause), 32'(m_cause));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int            n;
    logic          pll;
    logic [NS-1:0] src;
    logic [NS-1:0] mask;
    logic          sw;
    logic          clr;
    logic          e_rst;
    logic          e_rdy;
    logic [CW-1:0] e_cause;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(input int n, input logic pll, input logic [NS-1:0] src,
                              input logic [NS-1:0] mask, input logic sw, input logic clr,
                              input logic rst, input logic rdy, input logic [CW-1:0] cz);
    vec_t v;
    v.n = n; v.pll = pll; v.src = src; v.mask = mask; v.sw = sw; v.clr = clr;
    v.e_rst = rst; v.e_rdy = rdy; v.e_cause = cz;
    return v;
  endfunction

  initial begin
    int b;
    int lock_down;

    tbl.push_back(mk(33, 1, 2'b01, 2'b00, 0, 0, 1, 0, 5'b00001)); // power-up still in reset
    tbl.push_back(mk( 1, 1, 2'b01, 2'b00, 0, 0, 0, 1, 5'b00001)); // released at LK+ST+2
    tbl.push_back(mk( 5, 1, 2'b01, 2'b00, 0, 0, 0, 1, 5'b00001));
    tbl.push_back(mk( 1, 1, 2'b01, 2'b00, 0, 1, 0, 1, 5'b00000)); // clear in RUN
    tbl.push_back(mk( 1, 1, 2'b01, 2'b00, 1, 0, 1, 0, 5'b00010)); // sw request
    tbl.push_back(mk(11, 1, 2'b01, 2'b00, 0, 1, 1, 0, 5'b00010)); // clear ignored in STRETCH
    tbl.push_back(mk( 1, 1, 2'b01, 2'b00, 0, 0, 0, 1, 5'b00010));
    tbl.push_back(mk( 5, 1, 2'b00, 2'b00, 0, 0, 0, 1, 5'b00010)); // short glitch
    tbl.push_back(mk(10, 1, 2'b01, 2'b00, 0, 0, 0, 1, 5'b00010));
    tbl.push_back(mk(12, 1, 2'b00, 2'b00, 0, 0, 1, 0, 5'b01010)); // src0 debounced fall
    tbl.push_back(mk(12, 1, 2'b01, 2'b00, 0, 0, 0, 1, 5'b01010));
    tbl.push_back(mk(12, 1, 2'b11, 2'b10, 0, 0, 0, 1, 5'b01010)); // masked src1 rise
    tbl.push_back(mk(12, 1, 2'b01, 2'b10, 0, 0, 0, 1, 5'b01010));
    tbl.push_back(mk(12, 1, 2'b11, 2'b00, 0, 0, 1, 0, 5'b11010)); // unmasked src1 rise
    tbl.push_back(mk(12, 1, 2'b11, 2'b00, 0, 0, 0, 1, 5'b11010));
    tbl.push_back(mk( 1, 1, 2'b11, 2'b00, 0, 1, 0, 1, 5'b00000));
    tbl.push_back(mk( 2, 0, 2'b11, 2'b00, 0, 0, 0, 1, 5'b00000)); // lock drop in flight
    tbl.push_back(mk( 1, 0, 2'b11, 2'b00, 0, 0, 1, 0, 5'b00001)); // lock loss seen
    tbl.push_back(mk(33, 1, 2'b11, 2'b00, 0, 0, 1, 0, 5'b00001));
    tbl.push_back(mk( 1, 1, 2'b11, 2'b00, 0, 0, 0, 1, 5'b00001));
    tbl.push_back(mk( 1, 1, 2'b11, 2'b00, 1, 0, 1, 0, 5'b00011));
    tbl.push_back(mk( 6, 1, 2'b11, 2'b00, 0, 0, 1, 0, 5'b00011));
    tbl.push_back(mk( 1, 1, 2'b11, 2'b00, 1, 0, 1, 0, 5'b00011)); // retrigger mid-stretch
    tbl.push_back(mk(11, 1, 2'b11, 2'b00, 0, 0, 1, 0, 5'b00011));
    tbl.push_back(mk( 1, 1, 2'b11, 2'b00, 0, 0, 0, 1, 5'b00011));

    reset        = 1'b1;
    pll_locked   = 1'b1;
    src_in       = EM;
    src_mask     = '0;
    sw_reset_req = 1'b0;
    cause_clr    = 1'b0;
    wdt_kick     = 1'b0;
    model_reset();

    repeat (3) tick();
    check("reset_state_reset_out", 32'(reset_out), 32'd1);
    check("reset_state_ready", 32'(ready), 32'd0);
    check("reset_state_cause", 32'(cause), 32'h1);
    reset = 1'b0;

    foreach (tbl[k]) begin
      pll_locked   = tbl[k].pll;
      src_in       = tbl[k].src;
      src_mask     = tbl[k].mask;
      sw_reset_req = tbl[k].sw;
      cause_clr    = tbl[k].clr;
      repeat (tbl[k].n) tick();
      check($sformatf("vec%0d_reset_out", k), 32'(reset_out), 32'(tbl[k].e_rst));
      check($sformatf("vec%0d_ready", k), 32'(ready), 32'(tbl[k].e_rdy));
      check($sformatf("vec%0d_cause", k), 32'(cause), 32'(tbl[k].e_cause));
    end
    sw_reset_req = 1'b0;
    cause_clr    = 1'b0;

    // lock loss together with a software request: lock wins, both causes recorded
    cause_clr = 1'b1;
    tick();
    cause_clr  = 1'b0;
    pll_locked = 1'b0;
    repeat (2) tick();
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    check("lockloss_sw_reset_out", 32'(reset_out), 32'd1);
    check("lockloss_sw_cause", 32'(cause), 32'h3);
    pll_locked = 1'b1;
    repeat (LK + ST + 1) tick();
    check("relock_still_reset", 32'(reset_out), 32'd1);
    tick();
    check("relock_ready", 32'(ready), 32'd1);

    // clear and set in the same RUN cycle: set wins
    cause_clr    = 1'b1;
    sw_reset_req = 1'b1;
    tick();
    cause_clr    = 1'b0;
    sw_reset_req = 1'b0;
    check("clr_vs_set_cause", 32'(cause), 32'h2);
    check("clr_vs_set_reset_out", 32'(reset_out), 32'd1);
    repeat (ST) tick();
    check("clr_vs_set_ready", 32'(ready), 32'd1);

    // randomized traffic, one mid-run reset
    lock_down = 0;
    for (int c = 0; c < 4000; c++) begin
      reset        = (c == 2000);
      sw_reset_req = ($urandom_range(149) == 0);
      cause_clr    = ($urandom_range(39) == 0);
      wdt_kick     = 1'($urandom_range(1));
      if ($urandom_range(11) == 0) begin
        b = int'($urandom_range(NS - 1));
        src_in[b] = ~src_in[b];
      end
      if ($urandom_range(99) == 0) src_mask = NS'($urandom_range(3));
      if (lock_down > 0) begin
        pll_locked = 1'b0;
        lock_down--;
      end else begin
        pll_locked = 1'b1;
        if ($urandom_range(399) == 0) lock_down = int'($urandom_range(30, 1));
      end
      tick();
    end
    reset        = 1'b0;
    sw_reset_req = 1'b0;
    cause_clr    = 1'b0;
    check("cause_wdt_zero", 32'(cause[2]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
